// File: rtl/pt_pkg.sv
// Shared types and constants for the photoelectric tape reader emulator.
//   pt_state_t : reader FSM states
//   pt_frame_t : one 5-channel tape frame
//   PT_CODE_*  : frame codes the reader interprets
//   pt_max     : helper for sizing the shared period counter
package pt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FETCH,
    CAPTURE,
    GAP
  } pt_state_t;

  typedef logic [4:0] pt_frame_t;

  localparam pt_frame_t PT_CODE_STOP  = 5'b10000;
  localparam pt_frame_t PT_CODE_BLANK = 5'b00000;

  function automatic int unsigned pt_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pt_timer.sv
// Loadable down-counter with a single-cycle done pulse.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : start a new count of (load_val_i + 1) cycles
//   load_val_i   : terminal count minus one
//   done_o       : high in the last cycle of the loaded interval
module pt_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic         run_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/pt_reader.sv
// Photoelectric tape reader emulator. Steps through a 5-channel tape image
// in external RAM: forward motion delivers one frame per character period,
// reverse motion backs up one block.
//   CLOCK, rst                     : clock, synchronous active-high reset
//   PHOTO_TAPE_FWD/PHOTO_TAPE_REV  : level motion commands, sampled in IDLE
//   REWIND                         : pulse, position to 0 (idle only)
//   TAPE_LEN                       : frames in the image, 0 = no tape
//   TAPE_RD/TAPE_ADDR/TAPE_DATA    : RAM read port
//   PT_DATA/PT_STROBE              : delivered frame and its pulse
//   PT_STOP/PT_EOT/PT_BUSY/PT_POS  : status
//   dbg_state_o                    : current FSM state
//
// RAM handshake: no ready/valid back-pressure. TAPE_RD is a one-cycle request
// with TAPE_ADDR valid in the same cycle; the RAM must return TAPE_DATA in the
// next cycle, which is always the CAPTURE cycle.
module pt_reader
  import pt_pkg::*;
#(
  parameter int unsigned CHAR_PERIOD = 1000,
  parameter int unsigned START_DELAY = 500,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              PHOTO_TAPE_FWD,
  input  logic              PHOTO_TAPE_REV,
  input  logic              REWIND,
  input  logic [ADDR_W-1:0] TAPE_LEN,
  output logic              TAPE_RD,
  output logic [ADDR_W-1:0] TAPE_ADDR,
  input  pt_frame_t         TAPE_DATA,
  output pt_frame_t         PT_DATA,
  output logic              PT_STROBE,
  output logic              PT_STOP,
  output logic              PT_EOT,
  output logic              PT_BUSY,
  output logic [ADDR_W-1:0] PT_POS,
  output pt_state_t         dbg_state_o
);

  localparam int unsigned PCW = $clog2(pt_max(CHAR_PERIOD, START_DELAY) + 1);
  // START lasts START_DELAY cycles; GAP fills the period after FETCH+CAPTURE.
  localparam logic [PCW-1:0] START_LOAD = PCW'(START_DELAY - 1);
  localparam logic [PCW-1:0] GAP_LOAD   = PCW'(CHAR_PERIOD - 3);

  pt_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  pt_frame_t         data_q, data_d;
  logic              strobe_q, strobe_d;
  logic              stop_q, stop_d;
  logic              eot_q, eot_d;
  logic              fwd_q, fwd_d;      // direction of the current motion
  logic              first_q, first_d;  // no reverse step taken yet
  logic              ended_q, ended_d;  // stop code seen, finish after GAP

  logic              tmr_load;
  logic [PCW-1:0]    tmr_val;
  logic              tmr_done;

  pt_timer #(.W(PCW)) u_timer (
    .clk_i      (CLOCK),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    stop_d    = 1'b0;
    eot_d     = eot_q;
    fwd_d     = fwd_q;
    first_d   = first_q;
    ended_d   = ended_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    TAPE_RD   = 1'b0;
    TAPE_ADDR = '0;

    case (state_q)
      IDLE: begin
        if (REWIND) begin
          pos_d = '0;
          eot_d = 1'b0;
        end else if (PHOTO_TAPE_FWD && !PHOTO_TAPE_REV && !eot_q && (TAPE_LEN != '0)) begin
          state_d  = START;
          fwd_d    = 1'b1;
          first_d  = 1'b1;
          ended_d  = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = START_LOAD;
        end else if (PHOTO_TAPE_REV && !PHOTO_TAPE_FWD) begin
          state_d  = START;
          fwd_d    = 1'b0;
          first_d  = 1'b1;
          ended_d  = 1'b0;
          eot_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = START_LOAD;
        end
      end

      START: begin
        if (tmr_done) begin
          // Boundary guard so no read is issued outside 0..TAPE_LEN-1.
          if (fwd_q && (pos_q >= TAPE_LEN)) begin
            eot_d   = 1'b1;
            state_d = IDLE;
          end else if (!fwd_q && (pos_q == '0)) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        TAPE_RD   = 1'b1;
        TAPE_ADDR = fwd_q ? pos_q : (pos_q - ADDR_W'(1));
        state_d   = CAPTURE;
      end

      CAPTURE: begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LOAD;
        state_d  = GAP;
        if (fwd_q) begin
          pos_d = pos_q + ADDR_W'(1);
          if (TAPE_DATA == PT_CODE_STOP) begin
            stop_d  = 1'b1;
            ended_d = 1'b1;
          end else if (TAPE_DATA != PT_CODE_BLANK) begin
            data_d   = TAPE_DATA;
            strobe_d = 1'b1;
          end
        end else begin
          first_d = 1'b0;
          // A stop code behind the start point marks the previous block end:
          // park just after it, i.e. do not step over it.
          if ((TAPE_DATA == PT_CODE_STOP) && !first_q) ended_d = 1'b1;
          else                                          pos_d   = pos_q - ADDR_W'(1);
        end
      end

      GAP: begin
        if (tmr_done) begin
          if (fwd_q && (pos_q >= TAPE_LEN)) begin
            eot_d   = 1'b1;
            state_d = IDLE;
          end else if (ended_q) begin
            state_d = IDLE;
          end else if (fwd_q && !PHOTO_TAPE_FWD) begin
            state_d = IDLE;
          end else if (!fwd_q && (pos_q == '0)) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      stop_q   <= 1'b0;
      eot_q    <= 1'b0;
      fwd_q    <= 1'b0;
      first_q  <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      stop_q   <= stop_d;
      eot_q    <= eot_d;
      fwd_q    <= fwd_d;
      first_q  <= first_d;
      ended_q  <= ended_d;
    end
  end

  assign PT_DATA     = data_q;
  assign PT_STROBE   = strobe_q;
  assign PT_STOP     = stop_q;
  assign PT_EOT      = eot_q;
  assign PT_BUSY     = (state_q != IDLE);
  assign PT_POS      = pos_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pt_reader.sv
module tb_pt_reader;
  import pt_pkg::*;

  localparam int CP = 8;
  localparam int SD = 4;
  localparam int AW = 16;
  localparam int FOREVER_EDGE = 1 << 30;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          fwd, rev, rewind;
  logic [AW-1:0] tape_len;
  logic          tape_rd;
  logic [AW-1:0] tape_addr;
  pt_frame_t     tape_data;
  pt_frame_t     pt_data;
  logic          pt_strobe, pt_stop, pt_eot, pt_busy;
  logic [AW-1:0] pt_pos;
  pt_state_t     dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pt_reader #(.CHAR_PERIOD(CP), .START_DELAY(SD), .ADDR_W(AW)) dut (
    .CLOCK          (clk),
    .rst            (rst),
    .PHOTO_TAPE_FWD (fwd),
    .PHOTO_TAPE_REV (rev),
    .REWIND         (rewind),
    .TAPE_LEN       (tape_len),
    .TAPE_RD        (tape_rd),
    .TAPE_ADDR      (tape_addr),
    .TAPE_DATA      (tape_data),
    .PT_DATA        (pt_data),
    .PT_STROBE      (pt_strobe),
    .PT_STOP        (pt_stop),
    .PT_EOT         (pt_eot),
    .PT_BUSY        (pt_busy),
    .PT_POS         (pt_pos),
    .dbg_state_o    (dbg_state)
  );

  // Tape image RAM: data one cycle after the read strobe.
  logic [4:0] mem [0:15];
  always @(posedge clk) if (tape_rd) tape_data <= mem[tape_addr[3:0]];

  // ---------------- scoreboard ----------------
  int            exp_rd_cyc[$];
  logic [AW-1:0] exp_q[$];        // expected read addresses
  int            exp_stb_cyc[$];
  logic [4:0]    exp_stb_q[$];
  int            exp_stop_cyc[$];
  int            busy_from = 0;
  int            busy_until = 0;
  logic [AW-1:0] pos_m;
  logic          eot_m;
  int            idle_m;
  bit            mon_on = 1'b0;
  int            n_checks = 0;
  int            n_err = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: forward motion is a sequence of character periods starting
  // SD cycles after the sampled command; each period reads one frame.
  task automatic model_fwd(input int s, input int low_edge);
    int t;
    bit stopped;
    pt_frame_t f;
    stopped   = 1'b0;
    busy_from = s;
    idle_m    = s + SD;
    for (int k = 0; k < 64; k++) begin
      t = s + SD + k * CP;
      idle_m = t;
      if (pos_m >= tape_len) begin
        eot_m = 1'b1;
        break;
      end
      if (k > 0 && (stopped || low_edge <= t)) break;
      exp_rd_cyc.push_back(t);
      exp_q.push_back(pos_m);
      f = mem[pos_m[3:0]];
      if (f == 5'h10) begin
        exp_stop_cyc.push_back(t + 2);
        stopped = 1'b1;
      end else if (f != 5'h00) begin
        exp_stb_cyc.push_back(t + 2);
        exp_stb_q.push_back(f);
      end
      pos_m = pos_m + 1;
    end
    busy_until = idle_m;
  endtask

  // Model: reverse walks back frame by frame until the origin or until a
  // stop code is met beyond the first step (the reader parks after it).
  task automatic model_rev(input int s);
    int t;
    logic [AW-1:0] a;
    busy_from = s;
    idle_m    = s + SD;
    eot_m     = 1'b0;
    for (int k = 0; k < 64; k++) begin
      t = s + SD + k * CP;
      idle_m = t;
      if (pos_m == 0) break;
      a = pos_m - 1;
      exp_rd_cyc.push_back(t);
      exp_q.push_back(a);
      if (mem[a[3:0]] == 5'h10 && k > 0) begin
        idle_m = t + CP;
        break;
      end
      pos_m = a;
    end
    busy_until = idle_m;
  endtask

  task automatic flush_after(input int e);
    while (exp_rd_cyc.size() != 0 && exp_rd_cyc[$] > e) begin
      void'(exp_rd_cyc.pop_back()); void'(exp_q.pop_back());
    end
    while (exp_stb_cyc.size() != 0 && exp_stb_cyc[$] > e) begin
      void'(exp_stb_cyc.pop_back()); void'(exp_stb_q.pop_back());
    end
    while (exp_stop_cyc.size() != 0 && exp_stop_cyc[$] > e) void'(exp_stop_cyc.pop_back());
  endtask

  // Compare process: every cycle, mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_rd_cyc.size() != 0 && exp_rd_cyc[0] == cyc) begin
        check(tape_rd === 1'b1, "tape_rd", tape_rd, 1);
        check(tape_addr === exp_q[0], "tape_addr", tape_addr, exp_q[0]);
        void'(exp_rd_cyc.pop_front()); void'(exp_q.pop_front());
      end else if (tape_rd !== 1'b0) begin
        check(1'b0, "tape_rd_unexpected", tape_rd, 0);
      end
      if (exp_stb_cyc.size() != 0 && exp_stb_cyc[0] == cyc) begin
        check(pt_strobe === 1'b1, "pt_strobe", pt_strobe, 1);
        check(pt_data === exp_stb_q[0], "pt_data", pt_data, exp_stb_q[0]);
        void'(exp_stb_cyc.pop_front()); void'(exp_stb_q.pop_front());
      end else if (pt_strobe !== 1'b0) begin
        check(1'b0, "pt_strobe_unexpected", pt_strobe, 0);
      end
      if (exp_stop_cyc.size() != 0 && exp_stop_cyc[0] == cyc) begin
        check(pt_stop === 1'b1, "pt_stop", pt_stop, 1);
        void'(exp_stop_cyc.pop_front());
      end else if (pt_stop !== 1'b0) begin
        check(1'b0, "pt_stop_unexpected", pt_stop, 0);
      end
      check(pt_busy === (cyc >= busy_from && cyc < busy_until), "pt_busy", pt_busy,
            (cyc >= busy_from && cyc < busy_until));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_cmd(input bit f, input bit r, output int s);
    fwd = f;
    rev = r;
    step();
    s = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (pt_busy && n < 400) begin
      step();
      n++;
    end
    check(!pt_busy, {name, "_timeout"}, pt_busy, 0);
    check(cyc == idle_m, {name, "_idle_cycle"}, cyc, idle_m);
    check(pt_pos == pos_m, {name, "_pos"}, pt_pos, pos_m);
    check(pt_eot == eot_m, {name, "_eot"}, pt_eot, eot_m);
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    pos_m  = '0;
    eot_m  = 1'b0;
  endtask

  task automatic load_image(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] a3, input logic [4:0] a4, input int len);
    for (int i = 0; i < 16; i++) mem[i] = 5'h00;
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3; mem[4] = a4;
    tape_len = AW'(len);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    int e;
    rst = 1'b1; fwd = 1'b0; rev = 1'b0; rewind = 1'b0; tape_len = '0;
    for (int i = 0; i < 16; i++) mem[i] = 5'h00;
    repeat (3) step();
    check(pt_data == 5'h00, "rst_pt_data", pt_data, 0);
    check(pt_strobe == 1'b0, "rst_pt_strobe", pt_strobe, 0);
    check(pt_stop == 1'b0, "rst_pt_stop", pt_stop, 0);
    check(pt_eot == 1'b0, "rst_pt_eot", pt_eot, 0);
    check(pt_busy == 1'b0, "rst_pt_busy", pt_busy, 0);
    check(pt_pos == '0, "rst_pt_pos", pt_pos, 0);
    check(tape_rd == 1'b0, "rst_tape_rd", tape_rd, 0);
    check(dbg_state == IDLE, "rst_state", dbg_state, IDLE);
    rst = 1'b0;
    pos_m = '0; eot_m = 1'b0; idle_m = 0;
    mon_on = 1'b1;
    step();

    // Forward read up to a stop code.
    load_image(5'h03, 5'h00, 5'h07, 5'h10, 5'h05, 5);
    start_cmd(1'b1, 1'b0, s);
    model_fwd(s, FOREVER_EDGE);
    check(exp_stb_q.size() == 2, "pin_fwd_nstrobe", exp_stb_q.size(), 2);
    check(exp_stb_q[0] == 5'h03 && exp_stb_q[1] == 5'h07, "pin_fwd_data",
          {exp_stb_q[0], exp_stb_q[1]}, {5'h03, 5'h07});
    check(exp_stb_cyc[0] == s + 6 && exp_stb_cyc[1] - exp_stb_cyc[0] == 16, "pin_fwd_timing",
          exp_stb_cyc[1] - exp_stb_cyc[0], 16);
    check(exp_q[3] == 3 && exp_stop_cyc[0] == exp_rd_cyc[3] + 2, "pin_fwd_stop", exp_q[3], 3);
    check(pos_m == 4, "pin_fwd_pos", pos_m, 4);
    wait_idle("fwd");
    fwd = 1'b0;
    step();

    // Reverse one block from position 4.
    load_image(5'h01, 5'h10, 5'h02, 5'h03, 5'h10, 5);
    start_cmd(1'b0, 1'b1, s);
    rev = 1'b0;
    model_rev(s);
    check(exp_q.size() == 3 && exp_q[0] == 3 && exp_q[1] == 2 && exp_q[2] == 1,
          "pin_rev_addrs", exp_q.size(), 3);
    check(pos_m == 2, "pin_rev_pos", pos_m, 2);
    wait_idle("rev");
    step();

    // End of tape.
    do_rewind();
    load_image(5'h01, 5'h02, 5'h03, 5'h00, 5'h00, 3);
    start_cmd(1'b1, 1'b0, s);
    model_fwd(s, FOREVER_EDGE);
    check(exp_stb_q.size() == 3 && pos_m == 3 && eot_m == 1'b1, "pin_eot", pos_m, 3);
    wait_idle("eot");
    repeat (12) step();
    check(pt_busy == 1'b0 && pt_eot == 1'b1, "eot_fwd_ignored", pt_busy, 0);
    fwd = 1'b0;
    do_rewind();
    check(pt_pos == '0, "rewind_pos", pt_pos, 0);
    check(pt_eot == 1'b0, "rewind_eot", pt_eot, 0);

    // Forward dropped two cycles after the first strobe.
    start_cmd(1'b1, 1'b0, s);
    model_fwd(s, s + SD + 5);
    check(exp_stb_q.size() == 1 && pos_m == 1, "pin_drop", pos_m, 1);
    while (cyc < s + SD + 4) step();
    fwd = 1'b0;
    wait_idle("drop");

    // Both commands together: no motion.
    fwd = 1'b1; rev = 1'b1;
    repeat (12) step();
    check(pt_busy == 1'b0 && pt_pos == 1, "both_cmds_idle", pt_pos, 1);
    fwd = 1'b0; rev = 1'b0;
    step();

    // Reset during GAP.
    do_rewind();
    start_cmd(1'b1, 1'b0, s);
    model_fwd(s, FOREVER_EDGE);
    while (cyc < s + SD + 2) step();
    check(dbg_state == GAP, "pre_reset_state", dbg_state, GAP);
    e = cyc;
    rst = 1'b1;
    fwd = 1'b0;
    flush_after(e);
    busy_until = e + 1;
    pos_m = '0; eot_m = 1'b0;
    step();
    rst = 1'b0;
    check(pt_pos == '0 && pt_data == 5'h00 && pt_strobe == 1'b0, "reset_gap_outputs", pt_pos, 0);
    check(pt_busy == 1'b0 && tape_rd == 1'b0, "reset_gap_idle", pt_busy, 0);
    repeat (CP + SD + 4) step();
    check(pt_pos == '0, "reset_gap_pos_after", pt_pos, 0);

    // Reverse at origin.
    start_cmd(1'b0, 1'b1, s);
    rev = 1'b0;
    model_rev(s);
    check(exp_q.size() == 0 && idle_m == s + SD, "pin_rev0", idle_m - s, SD);
    wait_idle("rev0");
    repeat (4) step();

    check(exp_rd_cyc.size() + exp_stb_cyc.size() + exp_stop_cyc.size() == 0, "scoreboard_empty",
          exp_rd_cyc.size() + exp_stb_cyc.size() + exp_stop_cyc.size(), 0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
